// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I execute stage: ALU ops, branch funct3,
// forwarding selects and the multiplier FSM states.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    localparam logic [3:0] ALU_AUIPC = 4'b1011;
    localparam logic [3:0] ALU_MUL   = 4'b1100;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU plus the branch comparator.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [3:0]      alu_control_i,
    input  logic [2:0]      branch_control_i,
    output logic [XLEN-1:0] result_o,
    output logic            taken_o
);
    import riscv_pkg::*;

    logic [4:0] shamt;
    assign shamt = src_b_i[4:0];

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            ALU_ADD:   result_o = src_a_i + src_b_i;
            ALU_SUB:   result_o = src_a_i - src_b_i;
            ALU_AND:   result_o = src_a_i & src_b_i;
            ALU_OR:    result_o = src_a_i | src_b_i;
            ALU_XOR:   result_o = src_a_i ^ src_b_i;
            ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
            ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, src_a_i < src_b_i};
            ALU_SLL:   result_o = src_a_i << shamt;
            ALU_SRL:   result_o = src_a_i >> shamt;
            ALU_SRA:   result_o = $signed(src_a_i) >>> shamt;
            ALU_LUI:   result_o = src_b_i;
            ALU_AUIPC: result_o = pc_i + src_b_i;
            default:   result_o = '0;
        endcase
    end

    // Branches always compare against the forwarded rs2, never the immediate.
    always_comb begin
        taken_o = 1'b0;
        case (branch_control_i)
            BR_EQ:   taken_o = (src_a_i == rs2_i);
            BR_NE:   taken_o = (src_a_i != rs2_i);
            BR_LT:   taken_o = ($signed(src_a_i) < $signed(rs2_i));
            BR_GE:   taken_o = ($signed(src_a_i) >= $signed(rs2_i));
            BR_LTU:  taken_o = (src_a_i < rs2_i);
            BR_GEU:  taken_o = (src_a_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to add an iterative shift-add MUL (op 1100) that stalls the pipe via busy_e.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] rs1_data_e,
    input  logic [XLEN-1:0] rs2_data_e,
    input  logic [XLEN-1:0] immediate_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus_4_e,
    input  logic [4:0]      rd_e,
    input  logic            regwrite_e,
    input  logic            memwrite_e,
    input  logic            jump_e,
    input  logic            branch_e,
    input  logic            alu_src_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_control_e,
    input  logic [2:0]      branch_control_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] wb_result_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            busy_e,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      result_src_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus_4_m,
    output logic [4:0]      rd_m
);
    import riscv_pkg::*;

    logic [XLEN-1:0] src_a, rs2_fwd, src_b, alu_out, ex_result, jalr_sum;
    logic            taken, busy;

    logic            regwrite_q, memwrite_q;
    logic [1:0]      result_src_q;
    logic [XLEN-1:0] alu_result_q, write_data_q, pc_plus_4_q;
    logic [4:0]      rd_q;

    always_comb begin
        case (forward_a_e)
            FWD_WB:  src_a = wb_result_w;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = rs1_data_e;
        endcase
        case (forward_b_e)
            FWD_WB:  rs2_fwd = wb_result_w;
            FWD_MEM: rs2_fwd = alu_result_q;
            default: rs2_fwd = rs2_data_e;
        endcase
    end

    assign src_b = alu_src_e ? immediate_e : rs2_fwd;

    alu #(.XLEN(XLEN)) u_alu (
        .src_a_i          (src_a),
        .src_b_i          (src_b),
        .rs2_i            (rs2_fwd),
        .pc_i             (pc_e),
        .alu_control_i    (alu_control_e),
        .branch_control_i (branch_control_e),
        .result_o         (alu_out),
        .taken_o          (taken)
    );

    assign jalr_sum    = src_a + immediate_e;
    assign pc_target_e = (jump_e && alu_src_e) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + immediate_e;
    assign pc_src_e    = (jump_e | (branch_e & taken)) & ~busy;

`ifdef EX_MUL_EN
    mul_state_e      state_q;
    logic [4:0]      count_q;
    logic [XLEN-1:0] mcand_q, mplier_q, product_q;
    logic            mul_start;

    // busy must rise in the very cycle the MUL arrives so ID/EX is held; reset overrides it.
    assign mul_start = (state_q == MUL_IDLE) && (alu_control_e == ALU_MUL);
    assign busy      = ~reset & (mul_start | (state_q == MUL_BUSY));
    assign ex_result = (state_q == MUL_DONE) ? product_q : alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MUL_IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (mul_start) begin
                        mcand_q   <= src_a;
                        mplier_q  <= src_b;
                        product_q <= '0;
                        count_q   <= '0;
                        state_q   <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) begin
                        product_q <= product_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: state_q <= MUL_IDLE;
                default:  state_q <= MUL_IDLE;
            endcase
        end
    end
`else
    assign busy      = 1'b0;
    assign ex_result = alu_out;
`endif

    assign busy_e = busy;

    // A stalled EX stage hands MEM a bubble by dropping the write enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus_4_q  <= '0;
            rd_q         <= '0;
        end else begin
            regwrite_q   <= regwrite_e & ~busy;
            memwrite_q   <= memwrite_e & ~busy;
            result_src_q <= result_src_e;
            alu_result_q <= ex_result;
            write_data_q <= rs2_fwd;
            pc_plus_4_q  <= pc_plus_4_e;
            rd_q         <= rd_e;
        end
    end

    assign regwrite_m   = regwrite_q;
    assign memwrite_m   = memwrite_q;
    assign result_src_m = result_src_q;
    assign alu_result_m = alu_result_q;
    assign write_data_m = write_data_q;
    assign pc_plus_4_m  = pc_plus_4_q;
    assign rd_m         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed plan cases plus randomized ops against a behavioural model.
// Exercises the MUL FSM when EX_MUL_EN is defined, otherwise checks that op 1100 is inert.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rs1_data_e, rs2_data_e, immediate_e, pc_e, pc_plus_4_e, wb_result_w;
    logic [4:0]  rd_e;
    logic        regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_control_e;
    logic [2:0]  branch_control_e;

    logic        pc_src_e, busy_e, regwrite_m, memwrite_m;
    logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus_4_m;
    logic [1:0]  result_src_m;
    logic [4:0]  rd_m;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expAluM;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .rs1_data_e       (rs1_data_e),
        .rs2_data_e       (rs2_data_e),
        .immediate_e      (immediate_e),
        .pc_e             (pc_e),
        .pc_plus_4_e      (pc_plus_4_e),
        .rd_e             (rd_e),
        .regwrite_e       (regwrite_e),
        .memwrite_e       (memwrite_e),
        .jump_e           (jump_e),
        .branch_e         (branch_e),
        .alu_src_e        (alu_src_e),
        .result_src_e     (result_src_e),
        .alu_control_e    (alu_control_e),
        .branch_control_e (branch_control_e),
        .forward_a_e      (forward_a_e),
        .forward_b_e      (forward_b_e),
        .wb_result_w      (wb_result_w),
        .pc_src_e         (pc_src_e),
        .pc_target_e      (pc_target_e),
        .busy_e           (busy_e),
        .regwrite_m       (regwrite_m),
        .memwrite_m       (memwrite_m),
        .result_src_m     (result_src_m),
        .alu_result_m     (alu_result_m),
        .write_data_m     (write_data_m),
        .pc_plus_4_m      (pc_plus_4_m),
        .rd_m             (rd_m)
    );

    function automatic logic [31:0] modelAlu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] pc);
        int          sa, sb;
        logic [4:0]  sh;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        r  = 32'd0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  r = a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd10: r = b;
            4'd11: r = pc + b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic modelTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic applyStimulus();
        rs1_data_e = '0; rs2_data_e = '0; immediate_e = '0; pc_e = '0; pc_plus_4_e = '0;
        wb_result_w = '0; rd_e = '0; regwrite_e = 0; memwrite_e = 0; jump_e = 0; branch_e = 0;
        alu_src_e = 0; result_src_e = '0; alu_control_e = '0; branch_control_e = '0;
        forward_a_e = '0; forward_b_e = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m} !== 105'd0) begin
            failures++;
            $display("[TB] FAIL reset_exmem got=%h exp=0", {regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m});
        end
        checks++;
        if (busy_e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b exp=0", busy_e);
        end
        @(negedge clk);
        reset = 1'b0;
        expAluM = 32'd0;
    endtask

    task automatic test_add();
        @(negedge clk);
        applyStimulus();
        rs1_data_e = 32'd5; immediate_e = 32'hFFFF_FFF9; alu_src_e = 1; regwrite_e = 1;
        @(posedge clk); #1;
        checks++;
        if (alu_result_m !== 32'hFFFF_FFFE) begin
            failures++;
            $display("[TB] FAIL add_imm got=%h exp=fffffffe", alu_result_m);
        end
        checks++;
        if (regwrite_m !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_regwrite got=%b exp=1", regwrite_m);
        end
        expAluM = 32'hFFFF_FFFE;
    endtask

    task automatic test_forward();
        @(negedge clk);
        applyStimulus();
        rs1_data_e = 32'h10; alu_src_e = 1; regwrite_e = 1;
        @(posedge clk);
        @(negedge clk);
        applyStimulus();
        forward_a_e = 2'b10; rs2_data_e = 32'd3; alu_control_e = 4'd1; regwrite_e = 1;
        @(posedge clk); #1;
        checks++;
        if (alu_result_m !== 32'h0000_000D) begin
            failures++;
            $display("[TB] FAIL fwd_mem_sub got=%h exp=0000000d", alu_result_m);
        end
        expAluM = 32'h0000_000D;
    endtask

    task automatic test_branch();
        @(negedge clk);
        applyStimulus();
        branch_e = 1; branch_control_e = 3'd4; alu_control_e = 4'd1;
        rs1_data_e = 32'hFFFF_FFFF; rs2_data_e = 32'd1; pc_e = 32'h100; immediate_e = 32'h20;
        #1;
        checks++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h120}) begin
            failures++;
            $display("[TB] FAIL blt_taken got=%b/%h exp=1/00000120", pc_src_e, pc_target_e);
        end
        branch_control_e = 3'd6;
        #1;
        checks++;
        if (pc_src_e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bltu_not_taken got=%b exp=0", pc_src_e);
        end
        @(posedge clk); #1;
        expAluM = 32'hFFFF_FFFE;
    endtask

    task automatic test_jalr();
        @(negedge clk);
        applyStimulus();
        jump_e = 1; alu_src_e = 1; rs1_data_e = 32'h203; pc_e = 32'h400; pc_plus_4_e = 32'h404;
        regwrite_e = 1; result_src_e = 2'b10;
        #1;
        checks++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h202}) begin
            failures++;
            $display("[TB] FAIL jalr_target got=%b/%h exp=1/00000202", pc_src_e, pc_target_e);
        end
        @(posedge clk); #1;
        checks++;
        if ({pc_plus_4_m, result_src_m} !== {32'h404, 2'b10}) begin
            failures++;
            $display("[TB] FAIL jalr_link got=%h/%b exp=00000404/10", pc_plus_4_m, result_src_m);
        end
        expAluM = 32'h203;
    endtask

    task automatic test_reset_async();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m} !== 105'd0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h exp=0", {regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m});
        end
        applyStimulus();
        @(negedge clk);
        reset = 1'b0;
        expAluM = 32'd0;
    endtask

    task automatic test_random();
        logic [31:0] a, r2, b, expRes, expTarget;
        logic        expPcSrc;
        logic [3:0]  op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rs1_data_e  = $urandom;
            rs2_data_e  = ($urandom_range(0, 3) == 0) ? rs1_data_e : $urandom;
            immediate_e = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            pc_e        = $urandom;
            pc_plus_4_e = pc_e + 32'd4;
            wb_result_w = $urandom;
            rd_e        = 5'($urandom_range(0, 31));
            regwrite_e  = 1'($urandom_range(0, 1));
            memwrite_e  = 1'($urandom_range(0, 1));
            jump_e      = ($urandom_range(0, 4) == 0);
            branch_e    = 1'($urandom_range(0, 1));
            alu_src_e   = 1'($urandom_range(0, 1));
            result_src_e     = 2'($urandom_range(0, 3));
            branch_control_e = 3'($urandom_range(0, 7));
            forward_a_e      = 2'($urandom_range(0, 3));
            forward_b_e      = 2'($urandom_range(0, 3));
            op = 4'($urandom_range(0, 15));
            if (MUL_EN && op == 4'd12) op = 4'd0;
            alu_control_e = op;

            a  = (forward_a_e == 2'd1) ? wb_result_w : (forward_a_e == 2'd2) ? expAluM : rs1_data_e;
            r2 = (forward_b_e == 2'd1) ? wb_result_w : (forward_b_e == 2'd2) ? expAluM : rs2_data_e;
            b  = alu_src_e ? immediate_e : r2;
            expRes    = modelAlu(op, a, b, pc_e);
            expPcSrc  = jump_e | (branch_e & modelTaken(branch_control_e, a, r2));
            expTarget = (jump_e && alu_src_e) ? ((a + immediate_e) & 32'hFFFF_FFFE) : (pc_e + immediate_e);

            #1;
            checks++;
            if ({pc_src_e, pc_target_e} !== {expPcSrc, expTarget}) begin
                failures++;
                $display("[TB] FAIL rand_redirect[%0d] got=%b/%h exp=%b/%h", i, pc_src_e, pc_target_e, expPcSrc, expTarget);
            end
            @(posedge clk); #1;
            checks++;
            if ({alu_result_m, write_data_m, pc_plus_4_m, rd_m, regwrite_m, memwrite_m, result_src_m} !==
                {expRes, r2, pc_plus_4_e, rd_e, regwrite_e, memwrite_e, result_src_e}) begin
                failures++;
                $display("[TB] FAIL rand_exmem[%0d] op=%0d got=%h/%h/%h/%h/%b%b%b exp=%h/%h/%h/%h/%b%b%b", i, op,
                         alu_result_m, write_data_m, pc_plus_4_m, rd_m, regwrite_m, memwrite_m, result_src_m,
                         expRes, r2, pc_plus_4_e, rd_e, regwrite_e, memwrite_e, result_src_e);
            end
            expAluM = expRes;
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expProd;
        int          busyCycles, guard;
        bit          bubbleBad;
        expProd = a * b;
        @(negedge clk);
        applyStimulus();
        alu_control_e = 4'd12; rs1_data_e = a; rs2_data_e = b; regwrite_e = 1; memwrite_e = 1; rd_e = 5'd7;
        branch_e = 1; branch_control_e = 3'd1;
        busyCycles = 0; guard = 0; bubbleBad = 0;
        #1;
        while (busy_e === 1'b1 && guard < 100) begin
            busyCycles++;
            if (pc_src_e !== 1'b0) bubbleBad = 1;
            @(posedge clk); #1;
            guard++;
            if (regwrite_m !== 1'b0 || memwrite_m !== 1'b0) bubbleBad = 1;
        end
        checks++;
        if (busyCycles != 33) begin
            failures++;
            $display("[TB] FAIL mul_busy_cycles got=%0d exp=33", busyCycles);
        end
        checks++;
        if (bubbleBad) begin
            failures++;
            $display("[TB] FAIL mul_bubbles got=write_or_redirect_while_busy exp=none");
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_result_m, regwrite_m} !== {expProd, 1'b1}) begin
            failures++;
            $display("[TB] FAIL mul_result got=%h/%b exp=%h/1", alu_result_m, regwrite_m, expProd);
        end
        applyStimulus();
        @(posedge clk); #1;
        checks++;
        if (busy_e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_no_restart got=%b exp=0", busy_e);
        end
        expAluM = 32'd0;
    endtask

    task automatic test_mul_reset();
        @(negedge clk);
        applyStimulus();
        alu_control_e = 4'd12; rs1_data_e = 32'hDEAD_BEEF; rs2_data_e = 32'h1234; regwrite_e = 1;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy_e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mulrst_busy got=%b exp=0", busy_e);
        end
        checks++;
        if ({regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m} !== 105'd0) begin
            failures++;
            $display("[TB] FAIL mulrst_exmem got=%h exp=0", {regwrite_m, memwrite_m, result_src_m, alu_result_m, write_data_m, pc_plus_4_m, rd_m});
        end
        applyStimulus();
        @(negedge clk);
        reset = 1'b0;
        expAluM = 32'd0;
        test_mul(32'h0000_ABCD, 32'h0001_0003);
    endtask
`else
    task automatic test_mul_disabled();
        @(negedge clk);
        applyStimulus();
        alu_control_e = 4'd12; rs1_data_e = 32'h1234_5678; rs2_data_e = 32'h10; regwrite_e = 1;
        #1;
        checks++;
        if (busy_e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nomul_busy got=%b exp=0", busy_e);
        end
        @(posedge clk); #1;
        checks++;
        if ({alu_result_m, regwrite_m} !== {32'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL nomul_result got=%h/%b exp=00000000/1", alu_result_m, regwrite_m);
        end
        expAluM = 32'd0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        applyStimulus();
        expAluM = 32'd0;
        test_reset();
        test_add();
        test_forward();
        test_branch();
        test_jalr();
        test_reset_async();
        test_random();
`ifdef EX_MUL_EN
        test_mul(32'h1234_5678, 32'h0000_0010);
        test_mul_reset();
        test_mul($urandom, $urandom);
`else
        test_mul_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline. Consumes the ID/EX register contents and the hazard unit's forwarding selects. Computes the ALU result and resolves branches/jumps, redirecting fetch. Registers results into the EX/MEM pipeline register for the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs1_data_e / rs2_data_e  in  XLEN  register operands from ID/EX
- immediate_e  in  XLEN  sign-extended immediate
- pc_e / pc_plus_4_e  in  XLEN  PC and PC+4 of the instruction
- rd_e  in  5  destination register
- regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e  in  1  control bits
- result_src_e  in  2  writeback select, passed through
- alu_control_e  in  4  ALU op
- branch_control_e  in  3  branch funct3
- forward_a_e / forward_b_e  in  2  00 = ID/EX operand, 01 = wb_result_w, 10 = alu_result_m
- wb_result_w  in  XLEN  writeback-stage result
- pc_src_e  out  1  redirect fetch (combinational)
- pc_target_e  out  XLEN  redirect address (combinational)
- busy_e  out  1  multi-cycle op in progress; hazard unit stalls F/D and holds ID/EX
- regwrite_m, memwrite_m  out  1  EX/MEM control bits
- result_src_m  out  2  EX/MEM writeback select
- alu_result_m, write_data_m, pc_plus_4_m  out  XLEN  EX/MEM data
- rd_m  out  5  EX/MEM destination

## Operation
- srcA = forward mux A. Forwarded rs2 = mux B; it drives write_data_m. srcB = alu_src_e ? immediate_e : forwarded rs2. Select 11 behaves as 00.
- ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass srcB (LUI), 1011 pc_e+srcB (AUIPC). Undefined codes give 0. Shift amount is srcB[4:0]. All arithmetic wraps mod 2^XLEN.
- Branch condition on srcA vs forwarded rs2: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Other codes are never taken.
- pc_src_e = jump_e | (branch_e & taken).
- pc_target_e = jump_e & alu_src_e ? (srcA+imm)&~1 (JALR) : pc_e+imm.

## Timing
- EX/MEM captures on posedge clk when busy_e=0. With busy_e=1, a bubble is written: regwrite_m=0, memwrite_m=0, other fields don't-care.
- reset: all EX/MEM outputs 0, FSM IDLE, busy_e=0. Reset mid-multiply aborts the operation; no result is written.
- ALU ops: 1-cycle latency, EX to EX/MEM.
- pc_src_e is suppressed while busy_e=1.

## Configuration
- EX_MUL_EN defined: op 1100 is MUL (low XLEN bits), computed by an iterative shift-add FSM.
  - IDLE: on 1100, latch srcA/srcB, busy_e=1, clear counter, go to BUSY.
  - BUSY: one bit per cycle. Counter 0..31. busy_e=1. At counter 31, go to DONE.
  - DONE: busy_e=0. EX/MEM captures the product. Go to IDLE. DONE never restarts on the still-present op.
  - Instruction enters EX in cycle 0; result lands in EX/MEM at the end of cycle 33; busy_e is high in cycles 0..32.
- Undefined: 1100 yields 0, busy_e tied 0, no FSM.

## Structure
- riscv_pkg holds the ALU op codes, branch funct3 codes, forward select codes, and the FSM state enum.
- One sub-module, alu: combinational, covers ops 0000–1011 plus the branch compare.
- The multiplier FSM and the EX/MEM register live in ex_stage.

## Test plan
- ADD, srcA=5, imm=−7, alu_src=1, regwrite=1 → next cycle alu_result_m=0xFFFFFFFE, regwrite_m=1.
- forward_a=10, alu_result_m=0x10, rs1_data=0, SUB with rs2=3 → alu_result_m=0x0D.
- BLT, srcA=−1, rs2=1, pc=0x100, imm=0x20 → pc_src_e=1, pc_target_e=0x120. BLTU on the same operands → pc_src_e=0.
- JALR, srcA=0x203, imm=0 → pc_target_e=0x202, alu_result path gives pc_plus_4_m=pc+4.
- EX_MUL_EN: MUL 0x12345678×0x10 → busy_e high 33 cycles; then alu_result_m=0x23456780; bubbles (regwrite_m=0) during busy.
- Reset asserted at cycle 10 of a MUL → busy_e=0 and EX/MEM all zero immediately; next MUL completes normally.
